// File: rtl/disaster_pkg.sv
// Shared definitions for the disaster alarm controller: hazard bit indices,
// alarm code encodings, FSM states and the priority encoder.
package disaster_pkg;

    localparam int NUM_HAZ    = 4;
    localparam int FLOOD      = 0;
    localparam int CYCLONE    = 1;
    localparam int EARTHQUAKE = 2;
    localparam int TSUNAMI    = 3;

    typedef logic [2:0] alarm_code_t;

    localparam alarm_code_t CODE_NONE       = 3'd0;
    localparam alarm_code_t CODE_FLOOD      = 3'd1;
    localparam alarm_code_t CODE_CYCLONE    = 3'd2;
    localparam alarm_code_t CODE_EARTHQUAKE = 3'd3;
    localparam alarm_code_t CODE_TSUNAMI    = 3'd4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ALERT = 2'd1,
        ST_ACKED = 2'd2
    } state_t;

    // Highest-severity latched hazard wins: tsunami > earthquake > cyclone > flood.
    function automatic alarm_code_t prio_code(input logic [NUM_HAZ-1:0] flags);
        alarm_code_t code;
        code = CODE_NONE;
        if (flags[FLOOD])      code = CODE_FLOOD;
        if (flags[CYCLONE])    code = CODE_CYCLONE;
        if (flags[EARTHQUAKE]) code = CODE_EARTHQUAKE;
        if (flags[TSUNAMI])    code = CODE_TSUNAMI;
        return code;
    endfunction

endpackage

// File: rtl/disaster_alarm_ctrl_channel.sv
// One hazard channel: persistence / clear-run counting plus the latched and
// acknowledged flags for a single hazard input.
module hazard_channel
    import disaster_pkg::*;
#(
    parameter int PERSIST   = 3,
    parameter int CLEAR_CNT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic hazard,
    input  logic discard,
    input  logic ack_capture,
    input  logic clear_permit,
    output logic latch,
    output logic raise,
    output logic drop
);

    localparam int PW = $clog2(PERSIST + 1);
    localparam int CW = $clog2(CLEAR_CNT + 1);

    logic [PW-1:0] pcnt_reg;
    logic [CW-1:0] ccnt_reg;
    logic          latch_reg;
    logic          acked_reg;
    logic          sample;

    // Latch set/clear events for this edge; raise only counts a bit that is
    // newly set, and the clear run may already be saturated from before the ack.
    always_comb begin
        sample = tick & ~discard;
        raise  = sample & hazard & ~latch_reg & (pcnt_reg == PW'(PERSIST - 1));
        drop   = sample & ~hazard & latch_reg & acked_reg & clear_permit
               & (ccnt_reg >= CW'(CLEAR_CNT - 1));
    end

    // Counters, latch and acknowledge bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pcnt_reg  <= '0;
            ccnt_reg  <= '0;
            latch_reg <= 1'b0;
            acked_reg <= 1'b0;
        end else begin
            if (ack_capture) begin
                acked_reg <= latch_reg;
            end
            if (tick) begin
                if (discard) begin
                    pcnt_reg <= '0;
                    ccnt_reg <= '0;
                end else if (hazard) begin
                    ccnt_reg <= '0;
                    if (pcnt_reg != PW'(PERSIST)) pcnt_reg <= pcnt_reg + 1'b1;
                end else begin
                    pcnt_reg <= '0;
                    if (ccnt_reg != CW'(CLEAR_CNT)) ccnt_reg <= ccnt_reg + 1'b1;
                end
            end
            if (raise) begin
                latch_reg <= 1'b1;
            end
            if (drop) begin
                latch_reg <= 1'b0;
                acked_reg <= 1'b0;
            end
        end
    end

    assign latch = latch_reg;

endmodule

// File: rtl/disaster_alarm_ctrl.sv
// Alarm sequencer after the disaster decoder: sample divider, decoder mode
// control, four hazard channels, alert FSM with blinking buzzer, and the
// registered priority alarm code.
module disaster_alarm_ctrl
    import disaster_pkg::*;
#(
    parameter int SAMPLE_DIV = 1000,
    parameter int PERSIST    = 3,
    parameter int CLEAR_CNT  = 4,
    parameter int BLINK_DIV  = 500
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [3:0]   haz_in,
    input  logic         multi_en,
    input  logic         ack,
    output logic         mode_out,
    output logic [3:0]   alarm_led,
    output logic [2:0]   alarm_code,
    output logic         buzzer,
    output logic         sample_tick
);

    localparam int DW = $clog2(SAMPLE_DIV);
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    logic [DW-1:0]      div_reg;
    logic               sample_tick_reg;
    logic               mode_reg;
    logic               discard;
    logic               ack_capture;
    logic [NUM_HAZ-1:0] latch;
    logic [NUM_HAZ-1:0] raise;
    logic [NUM_HAZ-1:0] drop;
    logic [NUM_HAZ-1:0] latch_after;
    state_t             state_reg;
    logic [BW-1:0]      blink_reg;
    logic               buzzer_reg;
    alarm_code_t        code_reg;

    // Sample divider; the strobe is registered one count early so it is high
    // exactly while the divider sits at its last count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_reg         <= '0;
            sample_tick_reg <= 1'b0;
        end else begin
            if (div_reg == DW'(SAMPLE_DIV - 1)) div_reg <= '0;
            else                                 div_reg <= div_reg + 1'b1;
            sample_tick_reg <= (div_reg == DW'(SAMPLE_DIV - 2));
        end
    end

    // A mode change is only applied on a sample tick, and that sample is thrown away.
    always_comb begin
        discard     = sample_tick_reg & (multi_en != mode_reg);
        ack_capture = (state_reg == ST_ALERT) & ack;
        latch_after = (latch & ~drop) | raise;
    end

    // Decoder mode register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)          mode_reg <= 1'b0;
        else if (discard) mode_reg <= multi_en;
    end

    // Clearing is never vetoed at this level; the permit input lets a
    // supervisory override hold alarms in a future revision.
    generate
        for (genvar gi = 0; gi < NUM_HAZ; gi++) begin : g_chan
            hazard_channel #(
                .PERSIST   (PERSIST),
                .CLEAR_CNT (CLEAR_CNT)
            ) u_chan (
                .clk          (clk),
                .rst          (rst),
                .tick         (sample_tick_reg),
                .hazard       (haz_in[gi]),
                .discard      (discard),
                .ack_capture  (ack_capture),
                .clear_permit (1'b1),
                .latch        (latch[gi]),
                .raise        (raise[gi]),
                .drop         (drop[gi])
            );
        end
    endgenerate

    // Alert FSM with buzzer blink counter and registered alarm code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= ST_IDLE;
            blink_reg  <= '0;
            buzzer_reg <= 1'b0;
            code_reg   <= CODE_NONE;
        end else begin
            code_reg <= prio_code(latch_after);
            case (state_reg)
                ST_IDLE: begin
                    if (|raise) begin
                        state_reg  <= ST_ALERT;
                        buzzer_reg <= 1'b1;
                        blink_reg  <= '0;
                    end
                end
                ST_ALERT: begin
                    if (ack && !(|raise)) begin
                        state_reg  <= ST_ACKED;
                        buzzer_reg <= 1'b0;
                        blink_reg  <= '0;
                    end else if (blink_reg == BW'(BLINK_DIV - 1)) begin
                        blink_reg  <= '0;
                        buzzer_reg <= ~buzzer_reg;
                    end else begin
                        blink_reg <= blink_reg + 1'b1;
                    end
                end
                ST_ACKED: begin
                    if (|raise) begin
                        state_reg  <= ST_ALERT;
                        buzzer_reg <= 1'b1;
                        blink_reg  <= '0;
                    end else if (latch_after == '0) begin
                        state_reg <= ST_IDLE;
                    end
                end
                default: begin
                    state_reg  <= ST_IDLE;
                    buzzer_reg <= 1'b0;
                    blink_reg  <= '0;
                end
            endcase
        end
    end

    assign mode_out    = mode_reg;
    assign alarm_led   = latch;
    assign alarm_code  = code_reg;
    assign buzzer      = buzzer_reg;
    assign sample_tick = sample_tick_reg;

endmodule

// File: tb/tb_disaster_alarm_ctrl.sv
// Testbench for disaster_alarm_ctrl: directed scenarios followed by random
// hazard/ack/mode traffic, every clock compared with a behavioural model.
module tb_disaster_alarm_ctrl;

    localparam int SD = 4;
    localparam int P  = 3;
    localparam int C  = 2;
    localparam int BD = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] haz_in = 4'b0;
    logic       multi_en = 1'b0;
    logic       ack = 1'b0;
    logic       mode_out;
    logic [3:0] alarm_led;
    logic [2:0] alarm_code;
    logic       buzzer;
    logic       sample_tick;

    int checks = 0;
    int errors = 0;

    disaster_alarm_ctrl #(
        .SAMPLE_DIV (SD),
        .PERSIST    (P),
        .CLEAR_CNT  (C),
        .BLINK_DIV  (BD)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .haz_in      (haz_in),
        .multi_en    (multi_en),
        .ack         (ack),
        .mode_out    (mode_out),
        .alarm_led   (alarm_led),
        .alarm_code  (alarm_code),
        .buzzer      (buzzer),
        .sample_tick (sample_tick)
    );

    always #5 clk = ~clk;

    // Behavioural model: clocks since reset, hazard/clean run lengths per
    // channel, alarm and acknowledge sets, and the time ALERT was entered.
    int       cyc;
    int       m_phase;
    bit       m_mode;
    int       hrun [4];
    int       crun [4];
    bit [3:0] m_latch;
    bit [3:0] m_acked;
    int       m_state;    // 0 idle, 1 alert, 2 acked
    int       m_entry;

    function automatic bit [2:0] m_code(input bit [3:0] l);
        for (int i = 3; i >= 0; i--) if (l[i]) return 3'(i + 1);
        return 3'd0;
    endfunction

    task automatic model_reset();
        cyc = 0; m_phase = 0; m_mode = 0; m_latch = 0; m_acked = 0;
        m_state = 0; m_entry = 0;
        for (int i = 0; i < 4; i++) begin hrun[i] = 0; crun[i] = 0; end
    endtask

    task automatic model_step();
        bit [3:0] rise = 0;
        bit [3:0] clr  = 0;
        bit [3:0] old_latch = m_latch;
        cyc++;
        if (m_phase == SD - 1) begin
            if (multi_en != m_mode) begin
                m_mode = multi_en;
                for (int i = 0; i < 4; i++) begin hrun[i] = 0; crun[i] = 0; end
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (haz_in[i]) begin
                        crun[i] = 0;
                        if (hrun[i] < P) begin
                            hrun[i]++;
                            if (hrun[i] == P && !old_latch[i]) rise[i] = 1;
                        end
                    end else begin
                        hrun[i] = 0;
                        if (crun[i] < C) crun[i]++;
                        if (crun[i] == C && old_latch[i] && m_acked[i]) clr[i] = 1;
                    end
                end
            end
        end
        m_phase = (m_phase + 1) % SD;
        if (m_state == 1 && ack) m_acked = old_latch;
        m_acked = m_acked & ~clr;
        m_latch = (m_latch & ~clr) | rise;
        case (m_state)
            0: if (rise != 0) begin m_state = 1; m_entry = cyc; end
            1: if (ack && rise == 0) m_state = 2;
            default: begin
                if (rise != 0) begin m_state = 1; m_entry = cyc; end
                else if (m_latch == 0) m_state = 0;
            end
        endcase
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_model();
        bit exp_buz;
        exp_buz = (m_state == 1) && (((cyc - m_entry) / BD) % 2 == 0);
        chk("sample_tick", 8'(sample_tick), 8'(m_phase == SD - 1));
        chk("mode_out",    8'(mode_out),    8'(m_mode));
        chk("alarm_led",   8'(alarm_led),   8'(m_latch));
        chk("alarm_code",  8'(alarm_code),  8'(m_code(m_latch)));
        chk("buzzer",      8'(buzzer),      8'(exp_buz));
    endtask

    // One clock: advance the model with the current inputs, then compare.
    task automatic cycle();
        model_step();
        @(posedge clk);
        #1;
        check_model();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_ticks(input int n);
        run(n * SD);
    endtask

    task automatic pulse_ack();
        ack = 1'b1;
        cycle();
        ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        model_reset();
        chk("rst_led",    8'(alarm_led),   8'h00);
        chk("rst_code",   8'(alarm_code),  8'h00);
        chk("rst_buzzer", 8'(buzzer),      8'h00);
        chk("rst_mode",   8'(mode_out),    8'h00);
        chk("rst_tick",   8'(sample_tick), 8'h00);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        bit [3:0] exp_buz_seq;
        int       hold;

        // Reset and idle
        do_reset();
        $display("step reset/idle");
        run(40);
        chk("idle_led", 8'(alarm_led), 8'h00);

        // Flood held for three ticks raises the alarm; buzzer 1,1,0,0,1
        $display("step flood raise");
        haz_in = 4'b0001;
        wait_ticks(3);
        chk("flood_led",  8'(alarm_led),  8'h01);
        chk("flood_code", 8'(alarm_code), 8'h01);
        chk("flood_buz0", 8'(buzzer),     8'h01);
        exp_buz_seq = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("flood_blink", 8'(buzzer), 8'(exp_buz_seq[3 - i]));
        end

        // Tsunami on top of flood, ack, then both clear
        $display("step tsunami priority and clear");
        haz_in = 4'b1001;
        wait_ticks(3);
        chk("tsu_code", 8'(alarm_code), 8'h04);
        pulse_ack();
        chk("ack_buz", 8'(buzzer), 8'h00);
        run(3);
        haz_in = 4'b0000;
        wait_ticks(2);
        chk("clr_led",  8'(alarm_led),  8'h00);
        chk("clr_code", 8'(alarm_code), 8'h00);

        // Two hazardous ticks only: no alarm
        $display("step short hazard");
        haz_in = 4'b0001;
        wait_ticks(2);
        haz_in = 4'b0000;
        wait_ticks(2);
        chk("short_led", 8'(alarm_led), 8'h00);

        // Hazard gone before ack: stays latched, clears on tick after ack
        $display("step late ack");
        haz_in = 4'b0001;
        wait_ticks(3);
        haz_in = 4'b0000;
        wait_ticks(3);
        chk("late_hold", 8'(alarm_led), 8'h01);
        pulse_ack();
        run(3);
        chk("late_clear", 8'(alarm_led), 8'h00);

        // Cyclone raises on the same edge as ack for flood
        $display("step ack collision");
        haz_in = 4'b0001;
        wait_ticks(3);
        haz_in = 4'b0011;
        wait_ticks(2);
        run(3);
        pulse_ack();
        chk("coll_led", 8'(alarm_led), 8'h03);
        run(3);
        pulse_ack();
        chk("coll_ack2_buz", 8'(buzzer), 8'h00);
        run(3);
        haz_in = 4'b0000;
        wait_ticks(2);
        chk("coll_clear", 8'(alarm_led), 8'h00);

        // Mode change discards a sample and restarts persistence
        $display("step mode switch");
        haz_in = 4'b0100;
        wait_ticks(2);
        multi_en = 1'b1;
        wait_ticks(1);
        chk("mode_sw", 8'(mode_out), 8'h01);
        chk("mode_led0", 8'(alarm_led), 8'h00);
        wait_ticks(2);
        chk("mode_led1", 8'(alarm_led), 8'h00);
        wait_ticks(1);
        chk("mode_led2", 8'(alarm_led), 8'h04);
        chk("mode_code", 8'(alarm_code), 8'h03);

        // Reset while in ALERT
        $display("step reset in alert");
        cycle();
        do_reset();

        // Random traffic
        for (int t = 0; t < 150; t++) begin
            haz_in = 4'b0;
            for (int b = 0; b < 4; b++) haz_in[b] = ($urandom_range(0, 9) < 3);
            if ($urandom_range(0, 19) == 0) multi_en = ~multi_en;
            hold = $urandom_range(2, 16);
            $display("txn %0d haz=%b multi_en=%0d hold=%0d", t, haz_in, multi_en, hold);
            for (int k = 0; k < hold; k++) begin
                ack = ($urandom_range(0, 5) == 0);
                cycle();
            end
            ack = 1'b0;
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/disaster_alarm_ctrl.md
# disaster_alarm_ctrl

Sequencing and alarm-management controller placed after the combinational disaster decoder. It samples the decoder's four raw hazard flags (flood, cyclone, earthquake, tsunami) on a periodic sample tick and requires a hazard to persist before raising an alarm. Raised alarms stay latched until the operator acknowledges them and the hazard has cleared. The block also drives the decoder's `mode` input, switching it only on sample boundaries, and produces the user-facing latched LEDs, priority alarm code and buzzer pattern.

## Interface
- `SAMPLE_DIV`, 1000 — clocks per sample tick (≥2)
- `PERSIST`, 3 — consecutive hazardous samples needed to raise an alarm (≥1)
- `CLEAR_CNT`, 4 — consecutive clean samples needed to clear an alarm (≥1)
- `BLINK_DIV`, 500 — clocks per buzzer half-period (≥1)
- `clk` in 1 — system clock
- `rst` in 1 — asynchronous, active-high reset
- `haz_in` in 4 — raw decoder flags; [0] flood, [1] cyclone, [2] earthquake, [3] tsunami
- `multi_en` in 1 — requested decoder mode (0 unique, 1 multi)
- `ack` in 1 — operator acknowledge, level sampled each clock
- `mode_out` out 1 — mode applied to decoder
- `alarm_led` out 4 — latched alarms, same bit order as `haz_in`
- `alarm_code` out 3 — highest active alarm: 0 none, 1 flood, 2 cyclone, 3 earthquake, 4 tsunami
- `buzzer` out 1 — audible output
- `sample_tick` out 1 — one-cycle strobe, debug/observability

## Operation
- Divider counts 0..SAMPLE_DIV-1. `sample_tick`=1 when the count is SAMPLE_DIV-1. All sampling happens on tick edges only.
- Mode: if `multi_en`≠`mode_out` on a tick, `mode_out` updates, that tick's sample is discarded, and all persistence and clear counters reset to 0. Latched alarms are kept.
- Per channel i on a non-discarded tick:
  - If `haz_in[i]`=1: pcnt saturating-increments to PERSIST and ccnt←0. If pcnt==PERSIST-1 before the increment, latch[i]←1.
  - If `haz_in[i]`=0: pcnt←0 and ccnt saturating-increments to CLEAR_CNT. If latch[i]&acked[i] and ccnt==CLEAR_CNT-1 before the increment, latch[i]←0 and acked[i]←0.
- Unacked alarms: `pending` = latch & ~acked.
- FSM states:
  - IDLE (latch==0): → ALERT when any latch bit sets.
  - ALERT: `buzzer` toggles every BLINK_DIV clocks and starts at 1 on entry. `ack`=1 → acked←latch, → ACKED. If a latch bit sets on the same edge as `ack`, that bit stays unacked and the FSM stays in ALERT.
  - ACKED: `buzzer`=0. A new pending bit → ALERT. latch==0 → IDLE.
  - `ack` is ignored in IDLE and ACKED.
- `alarm_led`=latch. `alarm_code` is the priority encode of latch: tsunami > earthquake > cyclone > flood.

## Timing
- Reset values: every output 0; FSM IDLE; divider, pcnt, ccnt, latch, acked, blink counter all 0.
- First tick occurs SAMPLE_DIV clocks after reset release.
- Raise latency: an alarm appears on the edge of the PERSIST-th consecutive hazardous tick. `alarm_led`, `alarm_code` and the ALERT state update on that same edge, all registered. `buzzer`=1 from that edge.
- Clear latency: CLEAR_CNT consecutive clean ticks after ack. Ticks counted before the ack also count.
- A hazardous sample in the middle of a clear run restarts the clear count from 0.
- Reset mid-alarm clears everything immediately and asynchronously.
- All outputs are registered; nothing is combinational from input to output.

## Structure
- Package `disaster_pkg`: hazard index constants (FLOOD=0 … TSUNAMI=3), `alarm_code` encodings, FSM state enum.
- Sub-module `hazard_channel`, instantiated ×4. It holds pcnt, ccnt, latch and acked, with inputs tick, hazard, discard, ack_capture and clear-permit.
- The top level holds the divider, mode logic, FSM, priority encoder and blink counter.

## Test plan
Use SAMPLE_DIV=4, PERSIST=3, CLEAR_CNT=2, BLINK_DIV=2 for all scenarios.
- Reset, then idle 40 clocks with `haz_in`=0 → all outputs 0; `sample_tick` pulses every 4 clocks.
- `haz_in`=4'b0001 held for 3 ticks → `alarm_led`=0001 and `alarm_code`=1 on the 3rd tick edge; `buzzer` toggles 1,1,0,0,… Holding for only 2 ticks then 0 → no alarm.
- Alarms: flood latched, then tsunami → `alarm_code`=4. `ack` → `buzzer`=0 next edge. Both hazards drop → latch clears after 2 clean ticks → `alarm_code`=0, state IDLE.
- Hazard drops before `ack` → `alarm_led` stays set. Pulse `ack` after ≥2 clean ticks → clears on the next tick.
- Cyclone raises on the same edge `ack` is asserted for an already-latched flood → state stays ALERT; a second `ack` → ACKED.
- Toggle `multi_en` while a hazard is at pcnt=2 → `mode_out` changes on the next tick and that sample is discarded. The alarm then needs 3 further hazardous ticks.
- Assert `rst` while in ALERT → all outputs 0 immediately.
